// File: rtl/reservation_station.sv
// Unified reservation station for non-memory instructions.
// Holds renamed instructions until both source operands are available,
// snoops the ALU and LSB result buses to resolve pending ROB tags, and
// issues the lowest-index ready entry to the ALU through registered outputs.
module reservation_station #(
    parameter int RS_SIZE       = 16,
    parameter int IDWidth       = 32,
    parameter int ROBWidth      = 4,
    parameter int InstTypeWidth = 6,
    parameter int AddressWidth  = 32
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     dispatcher_rs_en_in,
    input  logic [IDWidth-1:0]       dispatcher_rs_a_in,
    input  logic [ROBWidth-1:0]      dispatcher_rs_qj_in,
    input  logic [ROBWidth-1:0]      dispatcher_rs_qk_in,
    input  logic [IDWidth-1:0]       dispatcher_rs_vj_in,
    input  logic [IDWidth-1:0]       dispatcher_rs_vk_in,
    input  logic [ROBWidth-1:0]      dispatcher_rs_dest_in,
    input  logic [AddressWidth-1:0]  dispatcher_rs_pc_in,
    input  logic [InstTypeWidth-1:0] dispatcher_rs_opcode_in,
    output logic                     rs_full_out,
    input  logic                     alu_cdb_en_in,
    input  logic [ROBWidth-1:0]      alu_cdb_tag_in,
    input  logic [IDWidth-1:0]       alu_cdb_value_in,
    input  logic                     lsb_cdb_en_in,
    input  logic [ROBWidth-1:0]      lsb_cdb_tag_in,
    input  logic [IDWidth-1:0]       lsb_cdb_value_in,
    input  logic                     rob_rs_clear_in,
    output logic                     rs_alu_en_out,
    output logic [InstTypeWidth-1:0] rs_alu_opcode_out,
    output logic [IDWidth-1:0]       rs_alu_vj_out,
    output logic [IDWidth-1:0]       rs_alu_vk_out,
    output logic [IDWidth-1:0]       rs_alu_a_out,
    output logic [AddressWidth-1:0]  rs_alu_pc_out,
    output logic [ROBWidth-1:0]      rs_alu_dest_out
);

    localparam int IdxWidth = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam logic [ROBWidth-1:0] NoTag = {ROBWidth{1'b0}};

    // A source operand: pending ROB tag (NoTag once the value is known) and value.
    typedef struct packed {
        logic [ROBWidth-1:0] q;
        logic [IDWidth-1:0]  v;
    } operand_t;

    // Resolve one operand against both result buses; the ALU bus wins a tie.
    function automatic operand_t resolve_operand(
        input logic [ROBWidth-1:0] q,
        input logic [IDWidth-1:0]  v,
        input logic                alu_en,
        input logic [ROBWidth-1:0] alu_tag,
        input logic [IDWidth-1:0]  alu_value,
        input logic                lsb_en,
        input logic [ROBWidth-1:0] lsb_tag,
        input logic [IDWidth-1:0]  lsb_value
    );
        operand_t res;
        res.q = q;
        res.v = v;
        if (q == NoTag) begin
            res.q = q;
        end else if (alu_en && (alu_tag == q)) begin
            res.q = NoTag;
            res.v = alu_value;
        end else if (lsb_en && (lsb_tag == q)) begin
            res.q = NoTag;
            res.v = lsb_value;
        end else begin
            res.q = q;
        end
        return res;
    endfunction

    logic [RS_SIZE-1:0]       busy_r;
    logic [InstTypeWidth-1:0] opcode_r [RS_SIZE];
    operand_t                 j_r      [RS_SIZE];
    operand_t                 k_r      [RS_SIZE];
    logic [IDWidth-1:0]       a_r      [RS_SIZE];
    logic [AddressWidth-1:0]  pc_r     [RS_SIZE];
    logic [ROBWidth-1:0]      dest_r   [RS_SIZE];

    operand_t                 wake_j_s [RS_SIZE];
    operand_t                 wake_k_s [RS_SIZE];
    operand_t                 disp_j_s;
    operand_t                 disp_k_s;
    logic                     free_found_s;
    logic [IdxWidth-1:0]      free_idx_s;
    logic                     issue_found_s;
    logic [IdxWidth-1:0]      issue_idx_s;

    logic                     alu_en_r;
    logic [InstTypeWidth-1:0] alu_opcode_r;
    logic [IDWidth-1:0]       alu_vj_r;
    logic [IDWidth-1:0]       alu_vk_r;
    logic [IDWidth-1:0]       alu_a_r;
    logic [AddressWidth-1:0]  alu_pc_r;
    logic [ROBWidth-1:0]      alu_dest_r;

    assign rs_full_out       = &busy_r;
    assign rs_alu_en_out     = alu_en_r;
    assign rs_alu_opcode_out = alu_opcode_r;
    assign rs_alu_vj_out     = alu_vj_r;
    assign rs_alu_vk_out     = alu_vk_r;
    assign rs_alu_a_out      = alu_a_r;
    assign rs_alu_pc_out     = alu_pc_r;
    assign rs_alu_dest_out   = alu_dest_r;

    // Lowest-index free entry for dispatch and lowest-index ready entry for issue.
    always_comb begin
        free_found_s  = 1'b0;
        free_idx_s    = {IdxWidth{1'b0}};
        issue_found_s = 1'b0;
        issue_idx_s   = {IdxWidth{1'b0}};
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_r[i]) begin
                free_found_s = 1'b1;
                free_idx_s   = IdxWidth'(i);
            end else if ((j_r[i].q == NoTag) && (k_r[i].q == NoTag)) begin
                issue_found_s = 1'b1;
                issue_idx_s   = IdxWidth'(i);
            end else begin
                issue_found_s = issue_found_s;
            end
        end
    end

    // Operand values after snooping the result buses: stored entries and incoming dispatch.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            wake_j_s[i] = resolve_operand(j_r[i].q, j_r[i].v,
                                          alu_cdb_en_in, alu_cdb_tag_in, alu_cdb_value_in,
                                          lsb_cdb_en_in, lsb_cdb_tag_in, lsb_cdb_value_in);
            wake_k_s[i] = resolve_operand(k_r[i].q, k_r[i].v,
                                          alu_cdb_en_in, alu_cdb_tag_in, alu_cdb_value_in,
                                          lsb_cdb_en_in, lsb_cdb_tag_in, lsb_cdb_value_in);
        end
        disp_j_s = resolve_operand(dispatcher_rs_qj_in, dispatcher_rs_vj_in,
                                   alu_cdb_en_in, alu_cdb_tag_in, alu_cdb_value_in,
                                   lsb_cdb_en_in, lsb_cdb_tag_in, lsb_cdb_value_in);
        disp_k_s = resolve_operand(dispatcher_rs_qk_in, dispatcher_rs_vk_in,
                                   alu_cdb_en_in, alu_cdb_tag_in, alu_cdb_value_in,
                                   lsb_cdb_en_in, lsb_cdb_tag_in, lsb_cdb_value_in);
    end

    // Entry state and issue registers: reset, freeze, flush, then wakeup/dispatch/issue.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_r       <= {RS_SIZE{1'b0}};
            alu_en_r     <= 1'b0;
            alu_opcode_r <= {InstTypeWidth{1'b0}};
            alu_vj_r     <= {IDWidth{1'b0}};
            alu_vk_r     <= {IDWidth{1'b0}};
            alu_a_r      <= {IDWidth{1'b0}};
            alu_pc_r     <= {AddressWidth{1'b0}};
            alu_dest_r   <= {ROBWidth{1'b0}};
            for (int i = 0; i < RS_SIZE; i++) begin
                opcode_r[i] <= {InstTypeWidth{1'b0}};
                j_r[i]      <= {$bits(operand_t){1'b0}};
                k_r[i]      <= {$bits(operand_t){1'b0}};
                a_r[i]      <= {IDWidth{1'b0}};
                pc_r[i]     <= {AddressWidth{1'b0}};
                dest_r[i]   <= {ROBWidth{1'b0}};
            end
        end else if (!rdy_in) begin
            alu_en_r <= 1'b0;
        end else if (rob_rs_clear_in) begin
            busy_r   <= {RS_SIZE{1'b0}};
            alu_en_r <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_r[i]) begin
                    j_r[i] <= wake_j_s[i];
                    k_r[i] <= wake_k_s[i];
                end
            end
            if (dispatcher_rs_en_in && free_found_s) begin
                busy_r[free_idx_s]   <= 1'b1;
                opcode_r[free_idx_s] <= dispatcher_rs_opcode_in;
                j_r[free_idx_s]      <= disp_j_s;
                k_r[free_idx_s]      <= disp_k_s;
                a_r[free_idx_s]      <= dispatcher_rs_a_in;
                pc_r[free_idx_s]     <= dispatcher_rs_pc_in;
                dest_r[free_idx_s]   <= dispatcher_rs_dest_in;
            end
            if (issue_found_s) begin
                busy_r[issue_idx_s] <= 1'b0;
                alu_en_r            <= 1'b1;
                alu_opcode_r        <= opcode_r[issue_idx_s];
                alu_vj_r            <= j_r[issue_idx_s].v;
                alu_vk_r            <= k_r[issue_idx_s].v;
                alu_a_r             <= a_r[issue_idx_s];
                alu_pc_r            <= pc_r[issue_idx_s];
                alu_dest_r          <= dest_r[issue_idx_s];
            end else begin
                alu_en_r <= 1'b0;
            end
        end
    end

endmodule

// File: doc/reservation_station.md
# reservation_station

Unified reservation station for non-memory instructions, sitting directly downstream of the dispatcher and upstream of the ALU. It accepts one renamed instruction per cycle with operand values or ROB tags, and snoops two common-data-bus (CDB) ports to resolve pending tags. It issues at most one ready instruction per cycle to the ALU through registered outputs, and supports a full flush on ROB misprediction recovery.

## Interface
- `RS_SIZE`, 16: number of entries; power of two.
- `IDWidth`, 32: data/immediate width.
- `ROBWidth`, 4: ROB tag width; tag 0 means "no dependency", valid tags are 1..2^ROBWidth-1.
- `InstTypeWidth`, 6: opcode width.
- `AddressWidth`, 32: PC width.

Ports:
- `clk_in`  in  1  clock; one clock domain.
- `rst_in`  in  1  synchronous, active-high reset.
- `rdy_in`  in  1  global enable; low freezes the block.
- `dispatcher_rs_en_in`  in  1  dispatch request.
- `dispatcher_rs_a_in`  in  IDWidth  immediate.
- `dispatcher_rs_qj_in` / `dispatcher_rs_qk_in`  in  ROBWidth  source tags (0 = value valid).
- `dispatcher_rs_vj_in` / `dispatcher_rs_vk_in`  in  IDWidth  source values.
- `dispatcher_rs_dest_in`  in  ROBWidth  destination ROB tag.
- `dispatcher_rs_pc_in`  in  AddressWidth  instruction PC.
- `dispatcher_rs_opcode_in`  in  InstTypeWidth  opcode.
- `rs_full_out`  out  1  all entries busy (combinational from state).
- `alu_cdb_en_in`, `alu_cdb_tag_in`, `alu_cdb_value_in`  in  1/ROBWidth/IDWidth  ALU result broadcast.
- `lsb_cdb_en_in`, `lsb_cdb_tag_in`, `lsb_cdb_value_in`  in  1/ROBWidth/IDWidth  load/store result broadcast.
- `rob_rs_clear_in`  in  1  misprediction flush.
- `rs_alu_en_out`  out  1  issue valid (one-cycle pulse).
- `rs_alu_opcode_out`, `rs_alu_vj_out`, `rs_alu_vk_out`, `rs_alu_a_out`, `rs_alu_pc_out`, `rs_alu_dest_out`  out  matching widths  issued instruction fields.

## Operation
- Entry state: busy, opcode, vj, qj, vk, qk, a, pc, dest.
- Reset: all busy cleared. All `rs_alu_*` outputs are 0. `rs_full_out` is 0.
- Priority at each edge: `rst_in` > `!rdy_in` > `rob_rs_clear_in` > normal operation.
- `rdy_in` low: entries frozen, dispatch and CDB inputs ignored, `rs_alu_en_out` driven to 0.
- Flush: all busy bits cleared, `rs_alu_en_out` set to 0, and any same-cycle dispatch and issue discarded.
- Dispatch: if `en` is high and `rs_full_out` is low, the lowest-index free entry is written.
  - If `en` is high while full, the request is dropped and no entry is modified; upstream must stall on `rs_full_out`.
- Dispatch bypass: if the incoming qj/qk is nonzero and equals a tag broadcast on an enabled CDB port in the same cycle, the entry stores the CDB value with q=0.
- Wakeup: for each busy entry and each source, if q≠0 and q equals an enabled CDB tag, then v takes the CDB value and q is set to 0.
  - Tag 0 never matches.
  - If both ports carry the same tag, the ALU port wins.
- Issue: the lowest-index busy entry with qj=0 and qk=0, evaluated on state at cycle start, is selected.
  - Its fields are registered to the `rs_alu_*` outputs, `rs_alu_en_out` goes to 1, and its busy bit is cleared at the same edge.
  - If no entry is ready, `rs_alu_en_out` goes to 0 and the other outputs hold their values.
- Full is computed from busy bits at cycle start. An entry freed by issue becomes allocatable the following cycle.
- An entry woken at edge k is first eligible for issue at edge k+1.

## Timing
- Dispatch at edge k with ready operands: issue at edge k+1; `rs_alu_en_out` is visible high during cycle k+1.
- Dispatch with a pending tag broadcast at cycle m ≥ k (via bypass or wakeup): issue at edge m+1 at the earliest.
- At most one dispatch and one issue per cycle. Throughput is 1/cycle when instructions are independent.
- `rs_full_out` is combinational from registered busy bits; there is no input-to-output combinational path.

## Test plan
- Reset, then dispatch ADD with qj=qk=0, vj=5, vk=7, dest=3 → the next cycle `rs_alu_en_out`=1, vj=5, vk=7, dest=3; `rs_full_out`=0 throughout.
- Dispatch with qj=4, then an ALU CDB broadcast of tag 4, value 0x1234, two cycles later → issue occurs the cycle after the broadcast with vj=0x1234.
- Dispatch with qk=6 in the same cycle that an LSB CDB broadcasts tag 6, value 9 → the entry captures 9 and issues the next cycle.
- Fill 16 entries with qj=2 → `rs_full_out`=1 and a 17th dispatch is dropped. Then broadcast tag 2 → entries issue in index order 0..15, one per cycle, and `rs_full_out` drops the cycle after the first issue.
- With 3 busy entries, assert `rob_rs_clear_in` together with a dispatch → the next cycle all entries are free, `rs_alu_en_out`=0, and no later issue occurs.
- Hold `rdy_in` low for 3 cycles with a ready entry and an active CDB → no issue and no wakeup occur. Release → the ready entry issues the next cycle.
